// File: rtl/cnu_pkg.sv
// Shared definitions for the min-sum check-node unit: sizing helpers and the
// (min, min2, idx) merge used by both the lane tree and the row accumulator.
package cnu_pkg;

  localparam int unsigned FieldW = 32;

  typedef struct packed {
    logic [FieldW-1:0] mn;
    logic [FieldW-1:0] mn2;
    logic [FieldW-1:0] idx;
  } min2_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned beats(input int unsigned dmax, input int unsigned p);
    return (dmax + p - 1) / p;
  endfunction

  function automatic logic [FieldW-1:0] maxmag(input int unsigned data_w);
    logic [63:0] t;
    t = (64'd1 << (data_w - 1)) - 64'd1;
    return t[FieldW-1:0];
  endfunction

  // Operand a wins ties: callers pass the lower-index edges as a.
  function automatic min2_t min2_merge(input min2_t a, input min2_t b);
    min2_t r;
    if (b.mn < a.mn) begin
      r.mn  = b.mn;
      r.idx = b.idx;
      r.mn2 = (a.mn < b.mn2) ? a.mn : b.mn2;
    end else begin
      r.mn  = a.mn;
      r.idx = a.idx;
      r.mn2 = (b.mn < a.mn2) ? b.mn : a.mn2;
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_min2_tree.sv
// Combinational per-beat reduction: masked lanes -> min, min2, lane index of
// the min and XOR of the unmasked signs.
module lane_min2_tree
  import cnu_pkg::*;
#(
  parameter int unsigned P      = 8,
  parameter int unsigned data_w = 9,
  parameter int unsigned idx_w  = 5
) (
  input  logic [P-1:0]        mask_i,
  input  logic [data_w*P-1:0] data_i,
  output logic [data_w-2:0]   min_o,
  output logic [data_w-2:0]   min2_o,
  output logic [idx_w-1:0]    idx_o,
  output logic                sgn_o
);

  localparam int unsigned Leaves = 1 << clog2(P);
  localparam int unsigned MagW   = data_w - 1;
  localparam logic [FieldW-1:0] MaxMag = maxmag(data_w);

  logic [Leaves-1:0]        mask_pad;
  logic [data_w*Leaves-1:0] data_pad;
  min2_t                    node [1:2*Leaves-1];
  logic                     sgn;

  assign mask_pad = Leaves'(mask_i);
  assign data_pad = (data_w*Leaves)'(data_i);

  // Heap-ordered tree: the left child always covers lower lanes, so ties go low.
  always_comb begin
    sgn = 1'b0;
    for (int i = 0; i < int'(Leaves); i++) begin
      node[Leaves+i] = '{mn: MaxMag, mn2: MaxMag, idx: FieldW'(i)};
      if (mask_pad[i]) begin
        node[Leaves+i].mn = FieldW'(data_pad[data_w*i +: MagW]);
        sgn = sgn ^ data_pad[data_w*i + MagW];
      end
    end
    for (int i = int'(Leaves) - 1; i >= 1; i--) begin
      node[i] = min2_merge(node[2*i], node[2*i+1]);
    end
  end

  assign min_o  = node[1].mn[MagW-1:0];
  assign min2_o = node[1].mn2[MagW-1:0];
  assign idx_o  = node[1].idx[idx_w-1:0];
  assign sgn_o  = sgn;

endmodule

// File: rtl/cnu_minsum_stream.sv
// Streaming min-sum check-node reduction: accumulates P-lane beats per row and
// emits min/min2/idx/sign one cycle after the row's last beat.
module cnu_minsum_stream
  import cnu_pkg::*;
#(
  parameter int unsigned data_w = 9,
  parameter int unsigned P      = 8,
  parameter int unsigned DMAX   = 32,
  parameter int unsigned idx_w  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_last,
  input  logic [P-1:0]        in_mask,
  input  logic [data_w*P-1:0] in_data,
  output logic                out_valid,
  output logic [data_w-2:0]   out_min,
  output logic [data_w-2:0]   out_min2,
  output logic [idx_w-1:0]    out_idx,
  output logic                out_sgn,
  output logic                out_err
);

  localparam int unsigned MagW  = data_w - 1;
  localparam int unsigned Beats = beats(DMAX, P);
  localparam int unsigned CntW  = (clog2(Beats) > 0) ? clog2(Beats) : 1;
  localparam logic [MagW-1:0] MaxMag = '1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [MagW-1:0]  acc_min_q, acc_min_d;
  logic [MagW-1:0]  acc_min2_q, acc_min2_d;
  logic [idx_w-1:0] acc_idx_q, acc_idx_d;
  logic             acc_sgn_q, acc_sgn_d;
  logic             out_valid_q, out_valid_d;
  logic [MagW-1:0]  out_min_q, out_min_d;
  logic [MagW-1:0]  out_min2_q, out_min2_d;
  logic [idx_w-1:0] out_idx_q, out_idx_d;
  logic             out_sgn_q, out_sgn_d;
  logic             err_q, err_d;

  logic [MagW-1:0]  beat_min, beat_min2;
  logic [idx_w-1:0] beat_lane, beat_base, beat_idx;
  logic             beat_sgn;
  min2_t            acc_t, beat_t, mrg;
  logic             mrg_sgn;

  lane_min2_tree #(
    .P      (P),
    .data_w (data_w),
    .idx_w  (idx_w)
  ) u_tree (
    .mask_i (in_mask),
    .data_i (in_data),
    .min_o  (beat_min),
    .min2_o (beat_min2),
    .idx_o  (beat_lane),
    .sgn_o  (beat_sgn)
  );

  // Edge index = beat*P + lane, deliberately truncated to idx_w.
  assign beat_base = idx_w'(32'(beat_cnt_q) * P);
  assign beat_idx  = beat_base + beat_lane;

  always_comb begin
    acc_t   = '{mn: FieldW'(acc_min_q), mn2: FieldW'(acc_min2_q), idx: FieldW'(acc_idx_q)};
    beat_t  = '{mn: FieldW'(beat_min), mn2: FieldW'(beat_min2), idx: FieldW'(beat_idx)};
    mrg     = min2_merge(acc_t, beat_t);
    mrg_sgn = acc_sgn_q ^ beat_sgn;
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    acc_min_d   = acc_min_q;
    acc_min2_d  = acc_min2_q;
    acc_idx_d   = acc_idx_q;
    acc_sgn_d   = acc_sgn_q;
    out_valid_d = 1'b0;
    out_min_d   = out_min_q;
    out_min2_d  = out_min2_q;
    out_idx_d   = out_idx_q;
    out_sgn_d   = out_sgn_q;
    err_d       = err_q;
    if (in_valid) begin
      if (in_last) begin
        out_valid_d = 1'b1;
        out_min_d   = mrg.mn[MagW-1:0];
        out_min2_d  = mrg.mn2[MagW-1:0];
        out_idx_d   = mrg.idx[idx_w-1:0];
        out_sgn_d   = mrg_sgn;
        acc_min_d   = MaxMag;
        acc_min2_d  = MaxMag;
        acc_idx_d   = '0;
        acc_sgn_d   = 1'b0;
        beat_cnt_d  = '0;
      end else begin
        acc_min_d  = mrg.mn[MagW-1:0];
        acc_min2_d = mrg.mn2[MagW-1:0];
        acc_idx_d  = mrg.idx[idx_w-1:0];
        acc_sgn_d  = mrg_sgn;
        if (beat_cnt_q == LastCnt) begin
          err_d = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      acc_min_q   <= MaxMag;
      acc_min2_q  <= MaxMag;
      acc_idx_q   <= '0;
      acc_sgn_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_min2_q  <= '0;
      out_idx_q   <= '0;
      out_sgn_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      acc_min_q   <= acc_min_d;
      acc_min2_q  <= acc_min2_d;
      acc_idx_q   <= acc_idx_d;
      acc_sgn_q   <= acc_sgn_d;
      out_valid_q <= out_valid_d;
      out_min_q   <= out_min_d;
      out_min2_q  <= out_min2_d;
      out_idx_q   <= out_idx_d;
      out_sgn_q   <= out_sgn_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_min   = out_min_q;
  assign out_min2  = out_min2_q;
  assign out_idx   = out_idx_q;
  assign out_sgn   = out_sgn_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_cnu_minsum_stream.sv
// Directed bench for cnu_minsum_stream (P=8, DMAX=32, data_w=9).
module tb_cnu_minsum_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_last;
  logic [7:0]  in_mask;
  logic [71:0] in_data;
  logic        out_valid;
  logic [7:0]  out_min;
  logic [7:0]  out_min2;
  logic [4:0]  out_idx;
  logic        out_sgn;
  logic        out_err;

  int          n_checks;
  int          n_fail;
  logic [71:0] dat;

  cnu_minsum_stream #(
    .data_w (9),
    .P      (8),
    .DMAX   (32),
    .idx_w  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_min   (out_min),
    .out_min2  (out_min2),
    .out_idx   (out_idx),
    .out_sgn   (out_sgn),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] mag);
    for (int i = 0; i < 8; i++) dat[9*i +: 9] = {1'b0, mag};
  endtask

  task automatic set_lane(input int i, input logic s, input logic [7:0] mag);
    dat[9*i +: 9] = {s, mag};
  endtask

  // Present one beat at the falling edge; returns one falling edge later.
  task automatic drive(input logic v, input logic l, input logic [7:0] m);
    in_valid = v;
    in_last  = l;
    in_mask  = m;
    in_data  = dat;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_row(input string tag, input logic [7:0] mn, input logic [7:0] mn2,
                           input logic [4:0] idx, input logic sgn);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".min"}, 32'(out_min), 32'(mn));
    check({tag, ".min2"}, 32'(out_min2), 32'(mn2));
    check({tag, ".idx"}, 32'(out_idx), 32'(idx));
    check({tag, ".sgn"}, 32'(out_sgn), 32'(sgn));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_mask  = '0;
    in_data  = '0;
    dat      = '0;
    repeat (2) @(negedge clk);
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.min", 32'(out_min), 32'd0);
    check("rst.min2", 32'(out_min2), 32'd0);
    check("rst.err", 32'(out_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single beat row.
    set_lane(0, 1'b1, 8'd5); set_lane(1, 1'b0, 8'd3); set_lane(2, 1'b0, 8'd9);
    set_lane(3, 1'b1, 8'd3); set_lane(4, 1'b0, 8'd7); set_lane(5, 1'b0, 8'd12);
    set_lane(6, 1'b0, 8'd1); set_lane(7, 1'b0, 8'd4);
    drive(1'b1, 1'b1, 8'hff);
    check_row("t1", 8'd1, 8'd3, 5'd6, 1'b0);
    @(negedge clk);
    check("t1.pulse", 32'(out_valid), 32'd0);
    check("t1.hold", 32'(out_min), 32'd1);

    // Four beats with a stall; acc wins the tie at mag 2.
    set_all(8'd20); set_lane(3, 1'b0, 8'd2);
    drive(1'b1, 1'b0, 8'hff);
    check("t2.novalid", 32'(out_valid), 32'd0);
    set_all(8'd20);
    drive(1'b1, 1'b0, 8'hff);
    drive(1'b0, 1'b0, 8'hff);
    set_lane(0, 1'b0, 8'd2); set_lane(1, 1'b0, 8'd2);
    drive(1'b1, 1'b0, 8'hff);
    set_all(8'd20);
    drive(1'b1, 1'b1, 8'hff);
    check_row("t2", 8'd2, 8'd2, 5'd3, 1'b0);

    // Back-to-back single-beat rows.
    set_all(8'd50); set_lane(5, 1'b1, 8'd10);
    drive(1'b1, 1'b1, 8'hff);
    check_row("t3a", 8'd10, 8'd50, 5'd5, 1'b1);
    set_all(8'd30); set_lane(2, 1'b0, 8'd7); set_lane(7, 1'b1, 8'd8); set_lane(0, 1'b1, 8'd30);
    drive(1'b1, 1'b1, 8'hff);
    check_row("t3b", 8'd7, 8'd8, 5'd2, 1'b0);

    // Single unmasked lane; masked lanes carry small mags and set signs.
    for (int i = 1; i < 8; i++) set_lane(i, 1'b1, 8'd0);
    set_lane(0, 1'b1, 8'd6);
    drive(1'b1, 1'b1, 8'b0000_0001);
    check_row("t4", 8'd6, 8'd255, 5'd0, 1'b1);

    // Fully masked row.
    drive(1'b1, 1'b1, 8'h00);
    check_row("t4m", 8'd255, 8'd255, 5'd0, 1'b0);

    // Degree overflow: err rises on the 4th non-last beat, then sticks.
    set_all(8'd100);
    for (int b = 0; b < 3; b++) drive(1'b1, 1'b0, 8'hff);
    check("t5.err3", 32'(out_err), 32'd0);
    drive(1'b1, 1'b0, 8'hff);
    check("t5.err4", 32'(out_err), 32'd1);
    set_lane(1, 1'b0, 8'd3);
    drive(1'b1, 1'b0, 8'hff);
    set_all(8'd100);
    drive(1'b1, 1'b1, 8'hff);
    check_row("t5", 8'd3, 8'd100, 5'd25, 1'b0);
    check("t5.errrow", 32'(out_err), 32'd1);
    drive(1'b1, 1'b1, 8'hff);
    check("t5.errnext", 32'(out_err), 32'd1);

    // Reset clears the sticky error.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5.errclr", 32'(out_err), 32'd0);

    // Reset during beat 2 of 3 discards the partial row.
    set_all(8'd40); set_lane(0, 1'b1, 8'd1);
    drive(1'b1, 1'b0, 8'hff);
    set_all(8'd40);
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_mask  = 8'hff;
    in_data  = dat;
    rst      = 1'b1;
    @(negedge clk);
    check("t6.abort", 32'(out_valid), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t6.idle", 32'(out_valid), 32'd0);
    set_all(8'd40); set_lane(4, 1'b1, 8'd9);
    drive(1'b1, 1'b1, 8'hff);
    check_row("t6", 8'd9, 8'd40, 5'd4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
